ecount_ctrl: RTL and testbench

- Controller that sequences the even-step counter datapath: 0, 1, 2, 4, 6, … up to a programmed limit, then wraps to 0.
- Accepts run, pause, step and clear commands over a valid/ready handshake.
- Counts a programmed number of wrap loops, then signals done.
- Sits between a host/sequencer FSM and any logic consuming the count value.

---
 rtl/ecount_pkg.sv | 22 ++
 rtl/ecount_core.sv | 51 +++++
 rtl/ecount_ctrl.sv | 149 ++++++++++++++
 tb/tb_ecount_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecount_pkg.sv
// Shared definitions for the even-step counter controller: command op codes,
// controller state encodings and the infinite-loop marker.
package ecount_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_PAUSE = 2'b01,
    OP_STEP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // A loop count of zero means run until told otherwise.
  localparam logic [3:0] LOOPS_INF = 4'd0;

endpackage

// File: rtl/ecount_core.sv
// Even-step counter datapath: 0, 1, 2, 4, 6, ... up to lim, then back to 0.
// wrap reports that the next advance returns the count to 0.
module ecount_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] lim,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   nxt;

  // Candidate next value, one bit wider so cnt+2 can never overflow.
  always_comb begin
    if (cnt_q == '0) begin
      nxt = (WIDTH+1)'(1);
    end else if (cnt_q == WIDTH'(1)) begin
      nxt = (WIDTH+1)'(2);
    end else begin
      nxt = {1'b0, cnt_q} + (WIDTH+1)'(2);
    end
    wrap = (cnt_q == lim) || (nxt > {1'b0, lim});
  end

  // Clear wins over advance; an advance either wraps to 0 or takes nxt.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = wrap ? '0 : nxt[WIDTH-1:0];
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ecount_ctrl.sv
// Even-step counter controller: command decode, run/pause/done FSM and loop
// counter around ecount_core. Define ECOUNT_CTRL_PRESCALE_EN to advance only
// once every PRESCALE RUN cycles.
module ecount_ctrl
  import ecount_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [3:0]       cfg_loops,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             done,
  output logic             busy,
  output logic [3:0]       loops_left
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [3:0]       loops_q, loops_d;
  logic             tc_q, tc_d, done_q, done_d;

  op_e  op;
  logic acc, is_start, is_pause, is_step, is_clear;
  logic run_tick, adv_req, core_wrap, final_wrap;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q != ST_DONE);
  assign acc       = cmd_valid & cmd_ready;
  assign is_start  = acc && (op == OP_START);
  assign is_pause  = acc && (op == OP_PAUSE);
  assign is_step   = acc && (op == OP_STEP);
  assign is_clear  = acc && (op == OP_CLEAR);

`ifdef ECOUNT_CTRL_PRESCALE_EN
  logic [7:0] presc_q, presc_d;
  logic       presc_hit;

  assign presc_hit = (presc_q == 8'(PRESCALE - 1));
  assign run_tick  = (state_q == ST_RUN) && presc_hit;

  // Prescaler counts RUN cycles, freezes in PAUSE, restarts on every RUN entry.
  always_comb begin
    presc_d = '0;
    if (!(is_start || is_clear)) begin
      if (state_q == ST_RUN) begin
        presc_d = presc_hit ? 8'd0 : presc_q + 8'd1;
      end else if (state_q == ST_PAUSE && !is_pause) begin
        presc_d = presc_q;
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic [7:0] unused_prescale;
  assign unused_prescale = 8'(PRESCALE);
  assign run_tick        = (state_q == ST_RUN);
`endif

  // STEP only advances from PAUSE; RUN advances regardless of PAUSE/STEP.
  assign adv_req    = run_tick || ((state_q == ST_PAUSE) && is_step);
  assign final_wrap = adv_req && core_wrap && (loops_q == 4'd1);

  ecount_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (is_start | is_clear),
    .adv   (adv_req),
    .lim   (lim_q),
    .cnt   (cnt),
    .wrap  (core_wrap)
  );

  // Next-state: START/CLEAR override any wrap; PAUSE is dropped on the final wrap.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    loops_d = loops_q;
    tc_d    = 1'b0;
    done_d  = 1'b0;
    if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (is_clear) begin
      state_d = ST_IDLE;
      loops_d = LOOPS_INF;
    end else if (is_start) begin
      state_d = ST_RUN;
      lim_d   = cfg_limit;
      loops_d = cfg_loops;
    end else begin
      if (adv_req && core_wrap) begin
        tc_d = 1'b1;
        if (loops_q == 4'd1) begin
          loops_d = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (loops_q != LOOPS_INF) begin
          loops_d = loops_q - 4'd1;
        end
      end
      if (is_pause && !final_wrap) begin
        if (state_q == ST_RUN) begin
          state_d = ST_PAUSE;
        end else if (state_q == ST_PAUSE) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lim_q   <= '0;
      loops_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      loops_q <= loops_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign tc         = tc_q;
  assign done       = done_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign loops_left = loops_q;

endmodule

// File: tb/tb_ecount_ctrl.sv
// Bench for ecount_ctrl: directed vector table, hand-written reset sequence,
// then random commands checked against a sequence-list reference model.
module tb_ecount_ctrl;
  import ecount_pkg::*;

  localparam int unsigned Presc = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cfg_limit;
  logic [3:0] cfg_loops;
  logic [3:0] cnt;
  logic       tc, done, busy;
  logic [3:0] loops_left;

  ecount_ctrl #(
    .WIDTH    (4),
    .PRESCALE (Presc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cfg_limit  (cfg_limit),
    .cfg_loops  (cfg_loops),
    .cnt        (cnt),
    .tc         (tc),
    .done       (done),
    .busy       (busy),
    .loops_left (loops_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the full count sequence for the latched limit is held in
  // a list and the model just walks an index through it.
  int m_mode;  // 0 idle, 1 run, 2 pause, 3 done
  int m_seq[$];
  int m_idx, m_loops, m_pc;
  bit m_tc, m_done;

  function automatic void model_reset();
    m_mode = 0; m_seq = {0}; m_idx = 0; m_loops = 0; m_pc = 0; m_tc = 0; m_done = 0;
  endfunction

  function automatic void build_seq(int lim);
    int v = 0;
    int n;
    m_seq = {0};
    while (1) begin
      n = (v == 0) ? 1 : (v == 1) ? 2 : v + 2;
      if (v == lim || n > lim) break;
      m_seq.push_back(n);
      v = n;
    end
  endfunction

  function automatic void model_step(bit v, int op, int lim, int lp);
    bit acc = v && (m_mode != 3);
    bit tick = 0;
    bit adv;
    if (m_mode == 3) begin
      m_mode = 0; m_tc = 0; m_done = 0;
      return;
    end
`ifdef ECOUNT_CTRL_PRESCALE_EN
    if (m_mode == 1) begin
      m_pc++;
      if (m_pc == Presc) begin tick = 1; m_pc = 0; end
    end
`else
    tick = (m_mode == 1);
`endif
    adv = tick || (m_mode == 2 && acc && op == 2);
    if (acc && op == 3) begin
      m_mode = 0; m_idx = 0; m_loops = 0; m_tc = 0; m_done = 0; m_pc = 0;
      return;
    end
    if (acc && op == 0) begin
      build_seq(lim);
      m_mode = 1; m_idx = 0; m_loops = lp; m_tc = 0; m_done = 0; m_pc = 0;
      return;
    end
    m_tc = 0; m_done = 0;
    if (adv) begin
      m_idx = (m_idx + 1) % m_seq.size();
      if (m_idx == 0) begin
        m_tc = 1;
        if (m_loops == 1) begin
          m_loops = 0; m_done = 1; m_mode = 3;
        end else if (m_loops > 1) begin
          m_loops--;
        end
      end
    end
    if (m_mode != 3 && acc && op == 1) begin
      if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2) begin m_mode = 1; m_pc = 0; end
    end
  endfunction

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit rst, input bit v, input logic [1:0] op,
                      input logic [3:0] lim, input logic [3:0] lp);
    reset = rst; cmd_valid = v; cmd_op = op; cfg_limit = lim; cfg_loops = lp;
    #1;
    chk("model ready", int'(cmd_ready), int'(m_mode != 3));
    if (rst) model_reset();
    else model_step(v, int'(op), int'(lim), int'(lp));
    @(posedge clk);
    #1;
    chk("model cnt", int'(cnt), m_seq[m_idx]);
    chk("model tc", int'(tc), int'(m_tc));
    chk("model done", int'(done), int'(m_done));
    chk("model busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
    chk("model loops_left", int'(loops_left), m_loops);
  endtask

  typedef struct {
    bit         v;
    logic [1:0] op;
    logic [3:0] lim;
    logic [3:0] lp;
    int         cnt;
    bit         tc;
    bit         dn;
    bit         bz;
    int         lf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit v, logic [1:0] op, int lim, int lp,
                              int c, bit t, bit d, bit b, int lf);
    vec_t r;
    r.v = v; r.op = op; r.lim = 4'(lim); r.lp = 4'(lp);
    r.cnt = c; r.tc = t; r.dn = d; r.bz = b; r.lf = lf;
    tbl.push_back(r);
  endfunction

  function automatic void idle(int c, bit t, bit d, bit b, int lf);
    add(0, OP_STEP, 0, 0, c, t, d, b, lf);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0] rop;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cfg_limit = '0; cfg_loops = '0;
    model_reset();
    tick(1, 0, OP_START, 0, 0);
    tick(1, 0, OP_START, 0, 0);
    chk("reset cnt", int'(cnt), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset ready", int'(cmd_ready), 1);

`ifndef ECOUNT_CTRL_PRESCALE_EN
    // limit 14, infinite loops, then pause / step / resume
    add(1, OP_START, 14, 0, 0, 0, 0, 1, 0);
    idle(1, 0, 0, 1, 0);  idle(2, 0, 0, 1, 0);  idle(4, 0, 0, 1, 0);
    idle(6, 0, 0, 1, 0);  idle(8, 0, 0, 1, 0);  idle(10, 0, 0, 1, 0);
    idle(12, 0, 0, 1, 0); idle(14, 0, 0, 1, 0); idle(0, 1, 0, 1, 0);
    idle(1, 0, 0, 1, 0);  idle(2, 0, 0, 1, 0);
    add(1, OP_PAUSE, 0, 0, 4, 0, 0, 1, 0);
    add(1, OP_STEP, 0, 0, 6, 0, 0, 1, 0);
    add(1, OP_STEP, 0, 0, 8, 0, 0, 1, 0);
    add(1, OP_PAUSE, 0, 0, 8, 0, 0, 1, 0);
    idle(10, 0, 0, 1, 0);
    add(1, OP_CLEAR, 0, 0, 0, 0, 0, 0, 0);
    // limit 7, two loops
    add(1, OP_START, 7, 2, 0, 0, 0, 1, 2);
    idle(1, 0, 0, 1, 2); idle(2, 0, 0, 1, 2); idle(4, 0, 0, 1, 2); idle(6, 0, 0, 1, 2);
    idle(0, 1, 0, 1, 1);
    idle(1, 0, 0, 1, 1); idle(2, 0, 0, 1, 1); idle(4, 0, 0, 1, 1); idle(6, 0, 0, 1, 1);
    idle(0, 1, 1, 0, 0);
    idle(0, 0, 0, 0, 0);
    // CLEAR, START and PAUSE landing on the final wrap (limit 1, one loop)
    add(1, OP_START, 1, 1, 0, 0, 0, 1, 1);
    idle(1, 0, 0, 1, 1);
    add(1, OP_CLEAR, 0, 0, 0, 0, 0, 0, 0);
    add(1, OP_START, 1, 1, 0, 0, 0, 1, 1);
    idle(1, 0, 0, 1, 1);
    add(1, OP_START, 1, 1, 0, 0, 0, 1, 1);
    idle(1, 0, 0, 1, 1);
    idle(0, 1, 1, 0, 0);
    idle(0, 0, 0, 0, 0);
    add(1, OP_START, 1, 1, 0, 0, 0, 1, 1);
    idle(1, 0, 0, 1, 1);
    add(1, OP_PAUSE, 0, 0, 0, 1, 1, 0, 0);
    add(1, OP_START, 5, 2, 0, 0, 0, 0, 0);  // DONE: not ready, ignored
    // limit 0: wraps on every advance
    add(1, OP_START, 0, 3, 0, 0, 0, 1, 3);
    idle(0, 1, 0, 1, 2); idle(0, 1, 0, 1, 1); idle(0, 1, 1, 0, 0);
    idle(0, 0, 0, 0, 0);
    add(1, OP_STEP, 0, 0, 0, 0, 0, 0, 0);
    add(1, OP_PAUSE, 0, 0, 0, 0, 0, 0, 0);
`else
    // limit 4 with a prescale of 3, then single steps in PAUSE
    add(1, OP_START, 4, 0, 0, 0, 0, 1, 0);
    idle(0, 0, 0, 1, 0); idle(0, 0, 0, 1, 0); idle(1, 0, 0, 1, 0);
    idle(1, 0, 0, 1, 0); idle(1, 0, 0, 1, 0); idle(2, 0, 0, 1, 0);
    add(1, OP_PAUSE, 0, 0, 2, 0, 0, 1, 0);
    add(1, OP_STEP, 0, 0, 4, 0, 0, 1, 0);
    add(1, OP_STEP, 0, 0, 0, 1, 0, 1, 0);
    add(1, OP_CLEAR, 0, 0, 0, 0, 0, 0, 0);
`endif

    foreach (tbl[i]) begin
      tick(0, tbl[i].v, tbl[i].op, tbl[i].lim, tbl[i].lp);
      chk($sformatf("row%0d cnt", i), int'(cnt), tbl[i].cnt);
      chk($sformatf("row%0d tc", i), int'(tc), int'(tbl[i].tc));
      chk($sformatf("row%0d done", i), int'(done), int'(tbl[i].dn));
      chk($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].bz));
      chk($sformatf("row%0d loops_left", i), int'(loops_left), tbl[i].lf);
    end

`ifndef ECOUNT_CTRL_PRESCALE_EN
    // Reset mid-run at cnt=10, then STEP in IDLE does nothing.
    tick(0, 1, OP_START, 14, 0);
    for (int k = 0; k < 6; k++) tick(0, 0, OP_START, 0, 0);
    chk("pre-reset cnt", int'(cnt), 10);
    tick(1, 1, OP_STEP, 0, 0);
    chk("reset-in-run cnt", int'(cnt), 0);
    chk("reset-in-run busy", int'(busy), 0);
    chk("reset-in-run tc", int'(tc), 0);
    chk("reset-in-run loops_left", int'(loops_left), 0);
    tick(0, 1, OP_STEP, 0, 0);
    chk("idle step cnt", int'(cnt), 0);
    chk("idle step busy", int'(busy), 0);
`endif

    // Random commands against the model.
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 15));
      rop = (r < 2) ? OP_START : (r < 8) ? OP_PAUSE : (r < 15) ? OP_STEP : OP_CLEAR;
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, rop,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
